uart_alu_intf: RTL

UART_ALU_INTF -- requirements
Module: uart_alu_intf

---
 rtl/uart_alu_pkg.sv | 36 +++
 rtl/intf_timeout_cnt.sv | 49 ++++
 rtl/uart_alu_intf.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/uart_alu_pkg.sv
//------------------------------------------------------------------------------
// Module  : uart_alu_pkg
// Brief   : Shared types and constants for the UART-to-ALU bridge: FSM state
//           encoding, default data/opcode widths and named ALU opcodes.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_alu_pkg;

  // Default widths of a UART byte / operand and of the ALU opcode
  localparam int DBIT_DEF = 8;
  localparam int OP_W_DEF = 6;

  // Frame sequencer states, in the order a frame is processed
  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    EXEC   = 3'd3,
    SEND   = 3'd4
  } state_e;

  // ALU opcodes (function field of the opcode byte)
  localparam logic [OP_W_DEF-1:0] OP_ADD = 6'h20;
  localparam logic [OP_W_DEF-1:0] OP_SUB = 6'h22;
  localparam logic [OP_W_DEF-1:0] OP_AND = 6'h24;
  localparam logic [OP_W_DEF-1:0] OP_OR  = 6'h25;
  localparam logic [OP_W_DEF-1:0] OP_XOR = 6'h26;
  localparam logic [OP_W_DEF-1:0] OP_NOR = 6'h27;
  localparam logic [OP_W_DEF-1:0] OP_SRA = 6'h03;
  localparam logic [OP_W_DEF-1:0] OP_SRL = 6'h02;

endpackage

`default_nettype wire

// File: rtl/intf_timeout_cnt.sv
//------------------------------------------------------------------------------
// Module  : intf_timeout_cnt
// Brief   : Inter-byte idle counter. Counts enabled cycles, clears on clr, and
//           flags expired once the count reaches TIMEOUT_CYC-1. Only built when
//           UART_ALU_INTF_TIMEOUT_EN is defined.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module intf_timeout_cnt #(
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic expired
);

  // Wide enough to hold TIMEOUT_CYC-1; at least one bit for tiny values
  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear has priority over counting
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_alu_intf.sv
//------------------------------------------------------------------------------
// Module  : uart_alu_intf
// Brief   : Pulls a 3-byte frame (A, B, opcode) from a UART receive FIFO,
//           presents it to an external combinational ALU, and pushes the
//           one-byte result into the UART transmit FIFO.
//           Optional feature macro: UART_ALU_INTF_TIMEOUT_EN -- abandons a
//           partial frame after TIMEOUT_CYC idle cycles between bytes.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_alu_intf
  import uart_alu_pkg::*;
#(
  parameter int DBIT        = DBIT_DEF,
  parameter int OP_W        = OP_W_DEF,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_empty,
  input  logic [DBIT-1:0] r_data,
  output logic            rd_uart,
  input  logic            tx_full,
  output logic            wr_uart,
  output logic [DBIT-1:0] w_data,
  output logic [DBIT-1:0] alu_a,
  output logic [DBIT-1:0] alu_b,
  output logic [OP_W-1:0] alu_op,
  input  logic [DBIT-1:0] alu_result,
  output logic            busy
);

  state_e          state_q, state_d;
  logic [DBIT-1:0] a_q, a_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [DBIT-1:0] res_q, res_d;
  logic            timeout_w;

`ifdef UART_ALU_INTF_TIMEOUT_EN
  logic waiting_w;
  logic expired_w;

  // Idle time only accumulates while mid-frame and starved of bytes
  assign waiting_w = (state_q == GET_B) || (state_q == GET_OP);
  assign timeout_w = waiting_w && expired_w;

  intf_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .en      (waiting_w && rx_empty),
    .clr     (rd_uart || timeout_w),
    .expired (expired_w)
  );
`else
  // Without the timeout a partial frame waits indefinitely
  assign timeout_w = 1'b0;
`endif

  // Next-state, register updates and FIFO strobes; strobes are held off
  // while reset is asserted so no FIFO traffic occurs during reset
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    rd_uart = 1'b0;
    wr_uart = 1'b0;
    if (reset) begin
      case (state_q)
        GET_A: begin
          if (!rx_empty) begin
            rd_uart = 1'b1;
            a_d     = r_data;
            state_d = GET_B;
          end
        end
        GET_B: begin
          if (!rx_empty) begin
            rd_uart = 1'b1;
            b_d     = r_data;
            state_d = GET_OP;
          end else if (timeout_w) begin
            state_d = GET_A;
          end
        end
        GET_OP: begin
          if (!rx_empty) begin
            rd_uart = 1'b1;
            op_d    = r_data[OP_W-1:0];
            state_d = EXEC;
          end else if (timeout_w) begin
            state_d = GET_A;
          end
        end
        EXEC: begin
          res_d   = alu_result;
          state_d = SEND;
        end
        SEND: begin
          if (!tx_full) begin
            wr_uart = 1'b1;
            state_d = GET_A;
          end
        end
        default: begin
          state_d = GET_A;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= GET_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  assign alu_a  = a_q;
  assign alu_b  = b_q;
  assign alu_op = op_q;
  assign w_data = res_q;
  assign busy   = (state_q != GET_A);

endmodule

`default_nettype wire
